// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if -- data-memory bus between the load/store unit and memory.
//
// Handshake: a request transfers on a rising edge where bus_req_valid and
// bus_req_ready are both high. Once raised, bus_req_valid and the request
// fields (bus_addr, bus_wen, bus_wmask, bus_wdata) stay stable until that
// edge. Only one access is outstanding at a time. bus_rsp_valid is a
// single-cycle pulse that carries read data (bus_rdata) or acknowledges a
// write. The unit waits for it after the request transfer.
//
// Signals:
//   bus_req_valid  master->slave  request valid
//   bus_req_ready  slave->master  request accepted
//   bus_addr       master->slave  word-aligned byte address
//   bus_wen        master->slave  1 = write
//   bus_wmask      master->slave  byte-lane write mask (0 on reads)
//   bus_wdata      master->slave  lane-aligned write data
//   bus_rsp_valid  slave->master  response / write acknowledge
//   bus_rdata      slave->master  read word
// -----------------------------------------------------------------------------
interface lsu_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_addr, bus_wen, bus_wmask, bus_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_wen, bus_wmask, bus_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit placed directly after the instruction decoder.
//
// It takes one memory operation per request, runs it on a single-outstanding
// valid/ready data bus, zero-extends load data and issues a one-cycle
// register-file write-back. lsu_busy stalls decode while an access is open.
//
// Optional build macro: LSU_MISALIGN_CHECK_EN
//   defined   : a misaligned lw (addr[1:0] != 0) or a store whose mask is
//               neither 4'b1111 nor one-hot completes straight away with
//               lsu_err = 1 and never reaches the bus.
//   undefined : no check; the word-aligned address is always issued.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles without a response before aborting with error
//   CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   lsu_valid         request strobe from decode
//   mem_wen           1 = store, 0 = load
//   mem_addr          byte address
//   mem_wmask         store byte-lane mask
//   mem_wdata         store data (rs2)
//   is_lbu            1 = lbu, 0 = lw
//   rd_addr           load destination register
//   lsu_ready         high only in IDLE
//   lsu_busy          ~lsu_ready, pipeline stall
//   bus               data-memory bus (lsu_if.master)
//   lsu_done          one-cycle completion pulse
//   lsu_err           with lsu_done: access timed out (or was misaligned)
//   rf_wen/rf_waddr/rf_wdata  register-file write-back
//   state_dbg         current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
// -----------------------------------------------------------------------------
module lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  input  logic        is_lbu,
  input  logic [4:0]  rd_addr,
  output logic        lsu_ready,
  output logic        lsu_busy,
  lsu_if.master       bus,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Request latches, captured when the request is accepted in IDLE.
  logic        wen_q;
  logic [31:0] addr_q;
  logic [3:0]  wmask_q;
  logic [31:0] wdata_q;
  logic        lbu_q;
  logic [4:0]  rd_q;

  // Registered outputs.
  logic        req_valid_q;
  logic        done_q;
  logic        err_q;
  logic        rf_wen_q;
  logic [31:0] rf_wdata_q;

  logic [31:0] load_data;

  function automatic logic is_onehot(input logic [3:0] m);
    return (m != 4'b0000) && ((m & (m - 4'b0001)) == 4'b0000);
  endfunction

  // Byte select for lbu works on the live response word so the result can
  // be registered on the same edge the response is seen.
  always_comb begin
    load_data = bus.bus_rdata;
    if (lbu_q) begin
      case (addr_q[1:0])
        2'd0:    load_data = {24'b0, bus.bus_rdata[7:0]};
        2'd1:    load_data = {24'b0, bus.bus_rdata[15:8]};
        2'd2:    load_data = {24'b0, bus.bus_rdata[23:16]};
        default: load_data = {24'b0, bus.bus_rdata[31:24]};
      endcase
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    if (!mem_wen && !is_lbu && (mem_addr[1:0] != 2'b00))
      misaligned = 1'b1;
    if (mem_wen && (mem_wmask != 4'b1111) && !is_onehot(mem_wmask))
      misaligned = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      lbu_q       <= 1'b0;
      rd_q        <= '0;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rf_wen_q    <= 1'b0;
      rf_wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            wen_q   <= mem_wen;
            addr_q  <= mem_addr;
            wmask_q <= mem_wmask;
            wdata_q <= mem_wdata;
            lbu_q   <= is_lbu;
            rd_q    <= rd_addr;
`ifdef LSU_MISALIGN_CHECK_EN
            if (misaligned) begin
              // Never touches the bus: finish at once with an error.
              state      <= DONE;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              rf_wen_q   <= 1'b0;
              rf_wdata_q <= '0;
            end else begin
              state       <= REQ;
              req_valid_q <= 1'b1;
            end
`else
            state       <= REQ;
            req_valid_q <= 1'b1;
`endif
          end
        end

        REQ: begin
          // Responses are not expected before the request transfers.
          if (bus.bus_req_ready) begin
            req_valid_q <= 1'b0;
            cnt         <= '0;
            state       <= WAIT;
          end
        end

        WAIT: begin
          // A response on the final timeout cycle still wins.
          if (bus.bus_rsp_valid) begin
            state      <= DONE;
            done_q     <= 1'b1;
            err_q      <= 1'b0;
            rf_wen_q   <= !wen_q && (rd_q != 5'd0);
            rf_wdata_q <= wen_q ? 32'd0 : load_data;
          end else if (cnt == CNT_LAST) begin
            state      <= DONE;
            done_q     <= 1'b1;
            err_q      <= 1'b1;
            rf_wen_q   <= 1'b0;
            rf_wdata_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          state      <= IDLE;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          rf_wen_q   <= 1'b0;
          rf_wdata_q <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign lsu_ready = (state == IDLE);
  assign lsu_busy  = ~lsu_ready;
  assign state_dbg = state;

  assign bus.bus_req_valid = req_valid_q;
  assign bus.bus_addr      = {addr_q[31:2], 2'b00};
  assign bus.bus_wen       = wen_q;
  assign bus.bus_wmask     = wen_q ? wmask_q : 4'b0000;
  // A single-lane store (sb) replicates its byte so every lane carries it.
  assign bus.bus_wdata     = is_onehot(wmask_q) ? {4{wdata_q[7:0]}} : wdata_q;

  assign lsu_done = done_q;
  assign lsu_err  = err_q;
  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rd_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu.
// Expected write-back results are queued when a request is driven and
// compared when lsu_done pulses.
// -----------------------------------------------------------------------------
module tb_lsu;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int W = 39;  // {err, rf_wen, rf_waddr[4:0], rf_wdata[31:0]}

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        lsu_valid;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        is_lbu;
  logic [4:0]  rd_addr;
  logic        lsu_ready;
  logic        lsu_busy;
  logic        lsu_done;
  logic        lsu_err;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  state_dbg;

  lsu_if bus();

  lsu #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .lsu_valid (lsu_valid),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .is_lbu    (is_lbu),
    .rd_addr   (rd_addr),
    .lsu_ready (lsu_ready),
    .lsu_busy  (lsu_busy),
    .bus       (bus),
    .lsu_done  (lsu_done),
    .lsu_err   (lsu_err),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Reference write-back for a finished access.
  function automatic logic [W-1:0] model(input logic wen, input logic [31:0] addr,
                                         input logic lbu, input logic [4:0] rd,
                                         input logic [31:0] rdata, input logic err);
    logic [31:0] d;
    logic        w;
    d = lbu ? ((rdata >> (8 * addr[1:0])) & 32'h0000_00FF) : rdata;
    w = !wen && !err && (rd != 5'd0);
    return {err, w, rd, d};
  endfunction

  // Scoreboard side: compare on every completion pulse.
  logic [W-1:0] e;
  always @(negedge clk) begin
    if (lsu_done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", lsu_done, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_err", lsu_err, e[38]);
        check("rf_wen", rf_wen, e[37]);
        check("rf_waddr", rf_waddr, e[36:32]);
        if (e[37]) check("rf_wdata", rf_wdata, e[31:0]);
      end
    end else if (rf_wen) begin
      check("rf_wen_no_done", rf_wen, 0);
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] wdata, input logic lbu, input logic [4:0] rd);
    lsu_valid = 1'b1;
    mem_wen   = wen;
    mem_addr  = addr;
    mem_wmask = mask;
    mem_wdata = wdata;
    is_lbu    = lbu;
    rd_addr   = rd;
    tick();
    lsu_valid = 1'b0;
  endtask

  // Immediate ready, response one cycle after the handshake.
  task automatic run_access(input logic wen, input logic [31:0] addr, input logic [3:0] mask,
                            input logic [31:0] wdata, input logic lbu, input logic [4:0] rd,
                            input logic [31:0] rdata);
    logic [31:0] exp_wdata;
    exp_q.push_back(model(wen, addr, lbu, rd, rdata, 1'b0));
    issue(wen, addr, mask, wdata, lbu, rd);
    bus.bus_req_ready = 1'b1;
    check("req_valid_n1", bus.bus_req_valid, 1);
    check("bus_addr", bus.bus_addr, {addr[31:2], 2'b00});
    check("bus_wen", bus.bus_wen, wen);
    check("bus_wmask", bus.bus_wmask, wen ? mask : 4'b0000);
    if (wen) begin
      exp_wdata = ($countones(mask) == 1) ? {4{wdata[7:0]}} : wdata;
      check("bus_wdata", bus.bus_wdata, exp_wdata);
    end
    check("busy", lsu_busy, 1);
    tick();                          // handshake
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b1;
    bus.bus_rdata     = rdata;
    check("req_drop", bus.bus_req_valid, 0);
    tick();                          // response seen
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rdata     = $urandom;
    check("done_n3", lsu_done, 1);
    tick();
    check("ready_after", lsu_ready, 1);
    check("done_clear", lsu_done, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int k;
    logic        r_wen, r_lbu;
    logic [31:0] r_addr;
    logic [3:0]  r_mask;
    int          r_sel;

    lsu_valid = 0; mem_wen = 0; mem_addr = 0; mem_wmask = 0;
    mem_wdata = 0; is_lbu = 0; rd_addr = 0;
    bus.bus_req_ready = 0; bus.bus_rsp_valid = 0; bus.bus_rdata = 0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", lsu_ready, 1);
    check("rst_busy", lsu_busy, 0);
    check("rst_req_valid", bus.bus_req_valid, 0);
    check("rst_done", lsu_done, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_bus_addr", bus.bus_addr, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b1;
    tick();

    // Directed cases.
    run_access(1'b0, 32'h8000_0004, 4'h0, 32'h0, 1'b0, 5'd5, 32'hDEAD_BEEF);  // lw
    run_access(1'b0, 32'h8000_0003, 4'h0, 32'h0, 1'b1, 5'd6, 32'hA1B2_C3D4);  // lbu
    run_access(1'b1, 32'h8000_0002, 4'b0100, 32'h1234_5678, 1'b0, 5'd3, 32'h0); // sb
    run_access(1'b1, 32'h8000_0008, 4'b1111, 32'hCAFE_F00D, 1'b0, 5'd4, 32'h0); // sw
    run_access(1'b0, 32'h8000_000C, 4'h0, 32'h0, 1'b0, 5'd0, 32'h5555_AAAA);  // rd = x0

    // Backpressure, ignored second request, then timeout.
    exp_q.push_back(model(1'b0, 32'h8000_0010, 1'b0, 5'd7, 32'h0, 1'b1));
    issue(1'b0, 32'h8000_0010, 4'h0, 32'h0, 1'b0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      check("bp_req_valid", bus.bus_req_valid, 1);
      check("bp_addr", bus.bus_addr, 32'h8000_0010);
      check("bp_wen", bus.bus_wen, 0);
      check("bp_busy", lsu_busy, 1);
      if (i == 1) begin
        lsu_valid = 1'b1; mem_wen = 1'b1; mem_addr = 32'h9000_0000;
        mem_wmask = 4'hF; rd_addr = 5'd9;
      end
      tick();
      lsu_valid = 1'b0;
    end
    check("bp_addr_held", bus.bus_addr, 32'h8000_0010);
    check("bp_wen_held", bus.bus_wen, 0);
    bus.bus_req_ready = 1'b1;
    tick();                          // handshake
    bus.bus_req_ready = 1'b0;
    k = 0;
    while (lsu_done !== 1'b1 && k < 3 * TIMEOUT_CYCLES) begin
      check("to_busy", lsu_busy, 1);
      tick();
      k++;
    end
    check("timeout_latency", k, TIMEOUT_CYCLES);
    check("timeout_err", lsu_err, 1);
    tick();
    check("to_ready", lsu_ready, 1);
    check("to_req_idle", bus.bus_req_valid, 0);

    // Reset while waiting for a response; the late response must be dropped.
    issue(1'b0, 32'h8000_0020, 4'h0, 32'h0, 1'b0, 5'd9);
    bus.bus_req_ready = 1'b1;
    tick();
    bus.bus_req_ready = 1'b0;
    tick();
    check("pre_rst_state", state_dbg, 2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_ready", lsu_ready, 1);
    check("mid_rst_req", bus.bus_req_valid, 0);
    bus.bus_rsp_valid = 1'b1;
    bus.bus_rdata     = 32'h1111_2222;
    tick();
    bus.bus_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_rsp_done", lsu_done, 0);
      check("late_rsp_rf_wen", rf_wen, 0);
      check("late_rsp_ready", lsu_ready, 1);
      tick();
    end

    // Random back-to-back traffic (aligned loads, full or one-hot stores).
    for (int n = 0; n < 24; n++) begin
      r_wen  = 1'($urandom_range(0, 1));
      r_lbu  = r_wen ? 1'b0 : 1'($urandom_range(0, 1));
      r_addr = $urandom;
      if (!r_wen && !r_lbu) r_addr[1:0] = 2'b00;
      r_sel  = $urandom_range(0, 4);
      r_mask = (r_sel == 4) ? 4'b1111 : 4'(1 << r_sel);
      run_access(r_wen, r_addr, r_mask, $urandom, r_lbu, 5'($urandom_range(0, 31)), $urandom);
    end

    repeat (2) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
